// File: rtl/logicnets_pkg.sv
// Shared constants and types for every inter-layer pipeline stage of the LUT network,
// so all layer boundaries agree on widths, occupancy encoding and drop accounting.
package logicnets_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int L1_WIDTH   = 32;
  localparam int L1_TAG_W   = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  // Saturating add of a small word count onto the drop counter.
  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                    input logic [1:0] b);
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, b};
    return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry skid buffer: 1-cycle latency from an empty stage, full throughput, s_ready
// is registered (low only when both entries hold data); flush empties it synchronously.
module skid_buffer_2
  import logicnets_pkg::*;
#(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output occ_t         occ
);

  occ_t         state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         rdy_q;
  logic         load_main, load_skid, main_from_skid;
  logic         in_xfer, out_xfer;

  assign in_xfer  = s_valid & rdy_q;
  assign out_xfer = m_valid & m_ready;
  assign m_valid  = (state_q != EMPTY);
  assign s_ready  = rdy_q;
  assign m_data   = main_q;
  assign occ      = state_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            load_main = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              load_skid = 1'b1;
              state_d   = FULL;
            end
            2'b01:   state_d = EMPTY;
            2'b11:   load_main = 1'b1;
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          if (out_xfer) begin
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Ready is derived from the next occupancy so it never depends combinationally on m_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
      if (load_main)           main_q <= s_data;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= s_data;
    end
  end

endmodule

// File: rtl/layer1_pipe_stage.sv
// Registered handshake stage between the layer-1 neuron LUTs and layer-2 inputs; wraps the
// two-entry skid buffer with the tag path and counts words discarded by flush.
module layer1_pipe_stage
  import logicnets_pkg::*;
#(
  parameter int WIDTH = L1_WIDTH,
  parameter int TAG_W = L1_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      s_data,
  input  logic [TAG_W-1:0]      s_tag,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic [TAG_W-1:0]      m_tag,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  occ_t                  occ;
  logic [1:0]            held;
  logic [1:0]            dropped;
  logic [DROP_CNT_W-1:0] drop_q;

  skid_buffer_2 #(.W(WIDTH + TAG_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .s_data  ({s_tag, s_data}),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  ({m_tag, m_data}),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .occ     (occ)
  );

  always_comb begin
    held = 2'd0;
    case (occ)
      ONE:     held = 2'd1;
      FULL:    held = 2'd2;
      default: held = 2'd0;
    endcase
  end

  // FULL implies s_ready=0, so held plus an accepted word never exceeds two.
  assign dropped  = held + {1'b0, s_valid & s_ready};
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (flush) begin
      drop_q <= sat_add(drop_q, dropped);
    end
  end

endmodule

// File: tb/tb_layer1_pipe_stage.sv
// Scoreboard bench for layer1_pipe_stage: directed stimulus with hand-computed expectations.
module tb_layer1_pipe_stage;
  localparam int WIDTH = 32;
  localparam int TAG_W = 8;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } word_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] s_data;
  logic [TAG_W-1:0] s_tag;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic [TAG_W-1:0] m_tag;
  logic             m_valid;
  logic             m_ready;
  logic             flush;
  logic [15:0]      drop_cnt;

  word_t sbq[$];
  word_t exp_w;
  word_t prev_w;
  logic  prev_stall = 1'b0;
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  layer1_pipe_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_tag    (s_tag),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_tag    (m_tag),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .flush    (flush),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t);
    int n;
    s_data  = d;
    s_tag   = t;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (!s_ready) check("send_timeout", 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
  endtask

  // Monitor: pushes accepted words, pops and compares on every output transfer.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_valid) check("stall_stable", 64'({m_tag, m_data}), 64'(prev_w));
      prev_stall = m_valid && !m_ready && !flush;
      prev_w     = {m_tag, m_data};
      if (flush) begin
        sbq.delete();
      end else begin
        if (m_valid && m_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_output", 64'(m_valid), 64'd0);
          end else begin
            exp_w = sbq.pop_front();
            check("out_word", 64'({m_tag, m_data}), 64'(exp_w));
          end
        end
        if (s_valid && s_ready) sbq.push_back({s_tag, s_data});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hA5A5_0F0F; s_tag = 8'h01;
    #12;
    check("rst_m_valid",  64'(m_valid),  64'd0);
    check("rst_s_ready",  64'(s_ready),  64'd1);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_m_data",   64'(m_data),   64'd0);
    check("rst_m_tag",    64'(m_tag),    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    check("first_m_valid", 64'(m_valid), 64'd1);
    check("first_m_data",  64'(m_data),  64'hA5A5_0F0F);
    check("first_m_tag",   64'(m_tag),   64'h01);
    s_valid = 1'b0; m_ready = 1'b1;
    step();
    check("first_drained", 64'(m_valid), 64'd0);

    // Streaming: back-to-back words must appear the cycle after acceptance.
    for (int i = 0; i < 100; i++) begin
      send(32'hC0DE_0000 + 32'(i), 8'(i));
      check("stream_tag",     64'(m_tag),   64'(i));
      check("stream_m_valid", 64'(m_valid), 64'd1);
      check("stream_s_ready", 64'(s_ready), 64'd1);
    end
    step();
    check("stream_drained", 64'(m_valid), 64'd0);

    // Backpressure: 5 and 6 fill the buffer, 7 waits upstream.
    m_ready = 1'b0;
    send(32'h0000_0505, 8'd5);
    check("bp_ready_one", 64'(s_ready), 64'd1);
    send(32'h0000_0606, 8'd6);
    check("bp_ready_full", 64'(s_ready), 64'd0);
    s_data = 32'h0000_0707; s_tag = 8'd7; s_valid = 1'b1;
    repeat (3) step();
    check("bp_hold_tag",   64'(m_tag),   64'd5);
    check("bp_hold_ready", 64'(s_ready), 64'd0);
    m_ready = 1'b1;
    send(32'h0000_0707, 8'd7);
    repeat (2) step();
    check("bp_drained", 64'(m_valid), 64'd0);

    // Simultaneous input and output in ONE.
    m_ready = 1'b0;
    send(32'h0000_0808, 8'd8);
    m_ready = 1'b1;
    send(32'h0000_0909, 8'd9);
    check("sim_tag",     64'(m_tag),   64'd9);
    check("sim_data",    64'(m_data),  64'h0000_0909);
    check("sim_m_valid", 64'(m_valid), 64'd1);
    check("sim_s_ready", 64'(s_ready), 64'd1);
    step();
    check("sim_drained", 64'(m_valid), 64'd0);

    // Flush in FULL with a blocked upstream word, then in ONE with an accepted word.
    m_ready = 1'b0;
    send(32'h0000_0A0A, 8'd10);
    send(32'h0000_0B0B, 8'd11);
    check("fl_full_ready", 64'(s_ready), 64'd0);
    s_data = 32'h0000_0C0C; s_tag = 8'd12; s_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; s_valid = 1'b0;
    check("fl_full_m_valid", 64'(m_valid),  64'd0);
    check("fl_full_drop",    64'(drop_cnt), 64'd2);
    check("fl_full_s_ready", 64'(s_ready),  64'd1);
    send(32'h0000_0D0D, 8'd13);
    s_data = 32'h0000_0E0E; s_tag = 8'd14; s_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; s_valid = 1'b0;
    check("fl_one_drop",    64'(drop_cnt), 64'd4);
    check("fl_one_m_valid", 64'(m_valid),  64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_empty_drop", 64'(drop_cnt), 64'd4);

    // Saturation: one flushed word per cycle.
    s_data = 32'hDEAD_BEEF; s_tag = 8'hEE; s_valid = 1'b1; flush = 1'b1;
    repeat (65530) step();
    check("sat_below", 64'(drop_cnt), 64'hFFFE);
    repeat (4466) step();
    check("sat_hold", 64'(drop_cnt), 64'hFFFF);
    flush = 1'b0;
    repeat (2) step();
    s_valid = 1'b0;
    check("pre_rst_m_valid", 64'(m_valid), 64'd1);
    check("pre_rst_s_ready", 64'(s_ready), 64'd0);

    // Asynchronous reset away from any clock edge.
    #2 rst = 1'b1;
    #1;
    check("arst_m_valid",  64'(m_valid),  64'd0);
    check("arst_s_ready",  64'(s_ready),  64'd1);
    check("arst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("arst_m_data",   64'(m_data),   64'd0);
    check("arst_m_tag",    64'(m_tag),    64'd0);
    step();
    rst = 1'b0;
    step();
    check("scoreboard_drain", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer1_pipe_stage.md
Name: layer1_pipe_stage

Overview:
- Registered handshake stage directly downstream of the layer-1 neuron LUTs.
- Captures the concatenated 1-bit outputs of all layer-1 neurons (N0..N(W-1)) together with a sample tag.
- Presents the captured vector to the layer-2 neuron inputs.
- A 2-entry skid buffer decouples the combinational layer-1 LUT cone from downstream backpressure, so the timing path breaks at every layer boundary without losing throughput.

Parameters:
- WIDTH, 32, number of layer-1 neurons; width of the data vector.
- TAG_W, 8, width of the sample tag carried alongside data.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  WIDTH  concatenated layer-1 neuron outputs; bit i = neuron Ni.
- s_tag  in  TAG_W  sample tag from the upstream stage.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  stage can accept a word.
- m_data  out  WIDTH  registered vector to the layer-2 inputs.
- m_tag  out  TAG_W  tag matching m_data.
- m_valid  out  1  m_data/m_tag valid.
- m_ready  in  1  downstream accepts.
- flush  in  1  synchronous discard of all held words.
- drop_cnt  out  16  count of words discarded by flush; saturating.

Behaviour:
- Reset (async assert, sync deassert assumed by the system):
  - m_valid=0, s_ready=1, m_data=0, m_tag=0, drop_cnt=0.
  - State is EMPTY; the skid register is cleared.
- Transfers:
  - An input transfer occurs when s_valid & s_ready at a rising edge.
  - An output transfer occurs when m_valid & m_ready.
- States (occupancy) and transitions:
  - EMPTY (0 words). An input transfer loads the main register; m_valid=1 next cycle; go to ONE.
  - ONE (main register valid).
    - Input only: load skid register, go to FULL.
    - Output only: go to EMPTY.
    - Input and output together: load main from s_data, stay in ONE.
    - Neither: hold.
  - FULL (main and skid both valid), s_ready=0.
    - Output transfer: main <= skid, go to ONE.
    - Otherwise hold.
- s_ready is a registered signal: 1 in EMPTY and ONE, 0 in FULL. There is no combinational path from m_ready to s_ready.
- Latency: 1 cycle from input transfer to m_valid when EMPTY.
- Throughput: 1 word/cycle sustained while m_ready=1.
- Ordering: strict FIFO. m_tag always travels with its own m_data.
- m_data and m_tag change only on entering ONE or FULL->ONE, or on a simultaneous in/out transfer in ONE. They are stable while m_valid=1 & m_ready=0.
- flush (synchronous, highest priority):
  - Next state is EMPTY and m_valid=0.
  - Any input transfer in the same cycle is also discarded.
  - drop_cnt += (number of words held) + (1 if an input transfer occurred). It saturates at 16'hFFFF.
- flush in EMPTY with no input transfer: no change, drop_cnt unchanged.
- Reset mid-operation: all held words are lost immediately. drop_cnt is cleared, not incremented.
- X-safety: the data registers need no reset for correctness, but are reset to 0 for deterministic simulation.

Decomposition:
- Shared package logicnets_pkg:
  - occupancy state enum {EMPTY, ONE, FULL}
  - DROP_CNT_W=16
  - default WIDTH/TAG_W constants, so all inter-layer stages agree.
- One natural sub-module: skid_buffer_2 (generic payload width = WIDTH+TAG_W).
  - Holds the state machine and both registers.
  - layer1_pipe_stage instantiates it and adds flush accounting and drop_cnt.
  - The same skid_buffer_2 is reused for every layer boundary.

Test Plan:
- Reset with s_valid=1 held.
  - During reset: m_valid=0, s_ready=1, drop_cnt=0.
  - After reset: s_data=32'hA5A5_0F0F, tag=8'h01 appears on m_data one cycle later with m_valid=1.
- Streaming: m_ready=1, 100 back-to-back words with tags 0..99 -> 100 outputs in order, no bubble after the first, s_ready constantly 1.
- Backpressure: m_ready=0 while sending tags 5,6,7.
  - Tags 5 and 6 are accepted; s_ready drops after tag 6.
  - Tag 7 is held upstream.
  - Release m_ready: outputs arrive as 5,6,7 with data unchanged while stalled.
- Simultaneous events in ONE: input and output on the same edge -> occupancy stays ONE, new data appears next cycle, no duplicate or loss.
- Flush in FULL with s_valid=1 and s_ready=0 -> m_valid=0 next cycle, drop_cnt=2. Repeat flush in ONE with an input transfer -> drop_cnt=4.
- Saturation and async reset: force 70000 flushed words -> drop_cnt=16'hFFFF. Then assert rst asynchronously mid-cycle -> outputs clear without waiting for a clk edge.
